uart_tx_byte_fifo: RTL and testbench

//   Byte FIFO between the HLS core's UART byte port (byte/start/response) and the

---
 rtl/uart_tx_byte_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_byte_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO between the core's UART byte port and the sendUART serializer.
// It acks each byte on store, drains in order one byte per start/finish handshake, and reports idle.
module uart_tx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] byte_in,
    input  logic                  send_in,
    output logic [1:0]            response_out,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  tx_start,
    input  logic                  tx_finish,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  idle,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]     count, count_next;
    logic                    pending, pending_next;
    logic [DATA_WIDTH-1:0]   pend_byte;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    full, push, pop, capture;

    // Handshake: send_in is a one-cycle request; response_out[0] pulses the
    // cycle after the byte is actually stored. tx_start is a one-cycle pulse
    // and tx_finish closes the transfer, except in the tx_start cycle itself.
    always_comb begin
        full       = (count == FULL_COUNT);
        push       = !full && (pending || send_in);
        wdata      = pending ? pend_byte : byte_in;
        capture    = send_in && !pending && full;
        pop        = 1'b0;
        state_next = state;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_finish && !tx_start) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        count_next = count;
        if (push && !pop)      count_next = count + CNT_ONE;
        else if (!push && pop) count_next = count - CNT_ONE;

        // A pending byte retires on the first cycle that starts below full.
        pending_next = pending;
        if (pending && !full) pending_next = 1'b0;
        if (capture)          pending_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending      <= 1'b0;
            pend_byte    <= '0;
            tx_byte      <= '0;
            tx_start     <= 1'b0;
            response_out <= 2'b00;
            idle         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            pending  <= pending_next;
            tx_start <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                tx_byte <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (capture)           pend_byte <= byte_in;
            if (send_in && pending) overflow <= 1'b1;
            // Flags are computed from next-state so they line up with count.
            response_out <= {count_next == FULL_COUNT, push};
            idle         <= (count_next == '0) && (state_next == S_IDLE) && !pending_next;
        end
    end

    assign fifo_count = count;

endmodule

// File: tb/tb_uart_tx_byte_fifo.sv
// Directed bench for uart_tx_byte_fifo: ack timing, full/pending/overflow,
// same-cycle push/pop, wrap-around streaming and asynchronous reset.
module tb_uart_tx_byte_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       send_in;
    logic [1:0] response_out;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_finish;
    logic [4:0] fifo_count;
    logic       idle;
    logic       overflow;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_tx_byte_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .send_in(send_in),
        .response_out(response_out), .tx_byte(tx_byte), .tx_start(tx_start),
        .tx_finish(tx_finish), .fifo_count(fifo_count), .idle(idle),
        .overflow(overflow)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // every serializer start seen is recorded for the scoreboard
    always @(negedge clk) if (tx_start === 1'b1) got_q.push_back(tx_byte);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_pulse();
        tx_finish = 1'b1;
        step();
        tx_finish = 1'b0;
    endtask

    task automatic send_wait_ack(input logic [7:0] b);
        bit seen;
        byte_in = b;
        send_in = 1'b1;
        step();
        send_in = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (response_out[0]) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("ack_seen", seen, 1'b1);
        exp_q.push_back(b);
    endtask

    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic producer(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) send_wait_ack(base + 8'(i));
    endtask

    task automatic consumer(input int n);
        for (int i = 0; i < n; i++) begin
            wait_start("stream_start");
            step(); step(); step();
            finish_pulse();
        end
    endtask

    initial begin
        reset = 1'b1; send_in = 1'b0; byte_in = '0; tx_finish = 1'b0;
        #3;
        chk("rst_resp", response_out, 2'b00);
        chk("rst_start", tx_start, 1'b0);
        chk("rst_count", fifo_count, 5'd0);
        chk("rst_idle", idle, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("idle_after_rst", idle, 1'b1);

        // 1: single byte timing
        byte_in = 8'h41; send_in = 1'b1;
        step();
        send_in = 1'b0;
        chk("t1_ack", response_out[0], 1'b1);
        chk("t1_count", fifo_count, 5'd1);
        step();
        chk("t1_start", tx_start, 1'b1);
        chk("t1_byte", tx_byte, 8'h41);
        chk("t1_ack_gone", response_out[0], 1'b0);
        chk("t1_idle_busy", idle, 1'b0);
        step();
        chk("t1_start_pulse", tx_start, 1'b0);
        repeat (5) step();
        chk("t1_byte_held", tx_byte, 8'h41);
        chk("t1_still_busy", idle, 1'b0);
        finish_pulse();
        chk("t1_idle", idle, 1'b1);
        exp_q.push_back(8'h41);
        check_sb("t1_sb");

        // 2: fill to full with tx_finish held low
        for (int i = 0; i <= 16; i++) begin
            byte_in = 8'(i); send_in = 1'b1;
            step();
            send_in = 1'b0;
            chk("t2_ack", response_out[0], 1'b1);
            exp_q.push_back(8'(i));
            step();
        end
        chk("t2_count_full", fifo_count, 5'd16);
        chk("t2_full_flag", response_out[1], 1'b1);
        byte_in = 8'h11; send_in = 1'b1;
        step();
        send_in = 1'b0;
        chk("t2_pend_noack", response_out[0], 1'b0);
        exp_q.push_back(8'h11);
        step();
        chk("t2_pend_noack2", response_out[0], 1'b0);
        chk("t2_count_hold", fifo_count, 5'd16);
        chk("t2_not_idle", idle, 1'b0);

        // 3: overflow while a byte is pending
        byte_in = 8'h22; send_in = 1'b1;
        step();
        send_in = 1'b0;
        chk("t3_ovf_noack", response_out[0], 1'b0);
        chk("t3_ovf", overflow, 1'b1);
        step(); step();
        chk("t3_pend_still", response_out[0], 1'b0);
        finish_pulse();
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (response_out[0]) begin
                    seen = 1'b1;
                    break;
                end
                step();
            end
            chk("t2_pend_ack", seen, 1'b1);
        end
        chk("t2_refull", fifo_count, 5'd16);
        for (int i = 0; i < 17; i++) begin
            step(); step(); step();
            finish_pulse();
        end
        step(); step();
        chk("t3_drained_idle", idle, 1'b1);
        chk("t3_ovf_sticky", overflow, 1'b1);
        check_sb("t23_sb");

        // 4: push in the same cycle as a pop from count==1
        send_wait_ack(8'h60);
        step(); step();
        send_wait_ack(8'h61);
        step(); step();
        chk("t4_count1", fifo_count, 5'd1);
        finish_pulse();
        byte_in = 8'h55; send_in = 1'b1;
        step();
        send_in = 1'b0;
        exp_q.push_back(8'h55);
        chk("t4_count_same", fifo_count, 5'd1);
        chk("t4_ack", response_out[0], 1'b1);
        chk("t4_start", tx_start, 1'b1);
        chk("t4_old_head", tx_byte, 8'h61);
        step(); step();
        finish_pulse();
        wait_start("t4_next_start");
        chk("t4_next_byte", tx_byte, 8'h55);
        step(); step();
        finish_pulse();
        step();
        chk("t4_idle", idle, 1'b1);
        check_sb("t4_sb");

        // 5: 40-byte stream across several pointer wraps
        do_reset();
        chk("t5_ovf_cleared", overflow, 1'b0);
        fork
            producer(40, 8'h80);
            consumer(40);
        join
        step(); step();
        chk("t5_ovf", overflow, 1'b0);
        chk("t5_idle", idle, 1'b1);
        check_sb("t5_sb");

        // 6: asynchronous reset in S_WAIT with 5 queued and tx_start high
        for (int i = 0; i < 7; i++) send_wait_ack(8'hC0 + 8'(i));
        step(); step();
        finish_pulse();
        wait_start("t6_start");
        chk("t6_count5", fifo_count, 5'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_start", tx_start, 1'b0);
        chk("t6_async_count", fifo_count, 5'd0);
        chk("t6_async_resp", response_out, 2'b00);
        chk("t6_async_idle", idle, 1'b0);
        step();
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        step();
        chk("t6_idle_after", idle, 1'b1);
        send_wait_ack(8'h7E);
        wait_start("t6_new_start");
        chk("t6_new_byte", tx_byte, 8'h7E);
        step(); step();
        finish_pulse();
        step();
        check_sb("t6_sb");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
